// File: rtl/l1d_lsq_arb.sv
// L1D front end: round-robin arbitration of two load ports onto the read port, an
// in-order speculative store queue draining committed words, and store-to-load forwarding.
module l1d_lsq_arb #(
    parameter int SQ_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld0_req_i,
    input  logic [ADDR_W-1:0]             ld0_addr_i,
    output logic                          ld0_gnt_o,
    output logic                          ld0_rvalid_o,
    output logic [DATA_W-1:0]             ld0_rdata_o,
    input  logic                          ld1_req_i,
    input  logic [ADDR_W-1:0]             ld1_addr_i,
    output logic                          ld1_gnt_o,
    output logic                          ld1_rvalid_o,
    output logic [DATA_W-1:0]             ld1_rdata_o,
    input  logic                          st_req_i,
    input  logic [ADDR_W-1:0]             st_addr_i,
    input  logic [DATA_W-1:0]             st_data_i,
    output logic                          st_rdy_o,
    input  logic                          st_commit_i,
    input  logic                          flush_i,
    output logic [$clog2(SQ_DEPTH):0]     sq_cnt_o,
    output logic                          sq_empty_o,
    output logic                          l1d_re_o,
    output logic [ADDR_W-1:0]             l1d_raddr_o,
    input  logic                          l1d_re_i,
    input  logic [DATA_W-1:0]             l1d_rdata_i,
    output logic                          l1d_we_o,
    output logic [ADDR_W-1:0]             l1d_waddr_o,
    output logic [DATA_W-1:0]             l1d_wdata_o
);

    localparam int PW    = $clog2(SQ_DEPTH);
    localparam int CNT_W = PW + 1;

    // Store queue storage
    logic [ADDR_W-1:0] addr_q [SQ_DEPTH];
    logic [DATA_W-1:0] data_q [SQ_DEPTH];

    // Queue pointers and counts; committed entries always form a prefix starting at head
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    cmt_q,  cmt_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d;

    // Arbitration and one-deep response tracking
    logic              rr_q, rr_d;
    logic              fwd_vld_q, fwd_vld_d;
    logic              rd_pend_q, rd_pend_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    logic              gnt0, gnt1, gnt_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              st_rdy, enq, pop, commit_ok;
    logic              resp_vld;
    logic [DATA_W-1:0] resp_data;

    // Grants are suppressed while reset is held so the read port stays quiet.
    always_comb begin
        gnt0     = rst && ld0_req_i && (!ld1_req_i || !rr_q);
        gnt1     = rst && ld1_req_i && (!ld0_req_i ||  rr_q);
        gnt_any  = gnt0 || gnt1;
        gnt_addr = gnt1 ? ld1_addr_i : ld0_addr_i;
    end

    // Youngest matching entry wins: later iterations overwrite earlier ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if ((CNT_W'(i) < cnt_q) &&
                (addr_q[head_q + PW'(i)][ADDR_W-1:2] == gnt_addr[ADDR_W-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PW'(i)];
            end
        end
    end

    always_comb begin
        st_rdy    = (cnt_q < CNT_W'(SQ_DEPTH));
        commit_ok = st_commit_i && (cnt_q != ccnt_q);
        pop       = (ccnt_q != '0);
        enq       = st_req_i && st_rdy && !flush_i;

        head_d = pop       ? head_q + PW'(1) : head_q;
        cmt_d  = commit_ok ? cmt_q  + PW'(1) : cmt_q;
        ccnt_d = ccnt_q + CNT_W'(commit_ok) - CNT_W'(pop);

        // Flush keeps only committed entries, counting a same-cycle commit and pop.
        if (flush_i) begin
            tail_d = cmt_d;
            cnt_d  = ccnt_d;
        end else begin
            tail_d = enq ? tail_q + PW'(1) : tail_q;
            cnt_d  = cnt_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_comb begin
        rr_d       = rr_q;
        if (gnt0)      rr_d = 1'b1;
        else if (gnt1) rr_d = 1'b0;
        fwd_vld_d  = gnt_any && fwd_hit;
        rd_pend_d  = gnt_any && !fwd_hit;
        owner_d    = gnt1;
        fwd_data_d = fwd_hit ? fwd_data : '0;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cmt_q      <= '0;
            cnt_q      <= '0;
            ccnt_q     <= '0;
            rr_q       <= 1'b0;
            fwd_vld_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            owner_q    <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cmt_q      <= cmt_d;
            cnt_q      <= cnt_d;
            ccnt_q     <= ccnt_d;
            rr_q       <= rr_d;
            fwd_vld_q  <= fwd_vld_d;
            rd_pend_q  <= rd_pend_d;
            owner_q    <= owner_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // NOTE: queue storage has no reset; an entry is only read while cnt covers it.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_data_i;
        end
    end

    always_comb begin
        resp_vld     = fwd_vld_q || (rd_pend_q && l1d_re_i);
        resp_data    = fwd_vld_q ? fwd_data_q : l1d_rdata_i;

        ld0_gnt_o    = gnt0;
        ld1_gnt_o    = gnt1;
        ld0_rvalid_o = resp_vld && !owner_q;
        ld1_rvalid_o = resp_vld &&  owner_q;
        ld0_rdata_o  = ld0_rvalid_o ? resp_data : '0;
        ld1_rdata_o  = ld1_rvalid_o ? resp_data : '0;

        l1d_re_o     = gnt_any && !fwd_hit;
        l1d_raddr_o  = l1d_re_o ? gnt_addr : '0;

        l1d_we_o     = pop;
        l1d_waddr_o  = pop ? addr_q[head_q] : '0;
        l1d_wdata_o  = pop ? data_q[head_q] : '0;

        st_rdy_o     = st_rdy;
        sq_cnt_o     = cnt_q;
        sq_empty_o   = (cnt_q == '0);
    end

endmodule

// File: tb/tb_l1d_lsq_arb.sv
// Randomized bench for l1d_lsq_arb: a queue-of-stores reference model predicts every
// output each cycle; a behavioural L1D RAM answers the DUT's read port.
module tb_l1d_lsq_arb;

    localparam int SQ_DEPTH = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ld0_req_i = 1'b0, ld1_req_i = 1'b0;
    logic [ADDR_W-1:0] ld0_addr_i = '0, ld1_addr_i = '0;
    logic              ld0_gnt_o, ld1_gnt_o, ld0_rvalid_o, ld1_rvalid_o;
    logic [DATA_W-1:0] ld0_rdata_o, ld1_rdata_o;
    logic              st_req_i = 1'b0, st_commit_i = 1'b0, flush_i = 1'b0;
    logic [ADDR_W-1:0] st_addr_i = '0;
    logic [DATA_W-1:0] st_data_i = '0;
    logic              st_rdy_o, sq_empty_o;
    logic [2:0]        sq_cnt_o;
    logic              l1d_re_o, l1d_we_o;
    logic [ADDR_W-1:0] l1d_raddr_o, l1d_waddr_o;
    logic [DATA_W-1:0] l1d_wdata_o;
    logic              l1d_re_i = 1'b0;
    logic [DATA_W-1:0] l1d_rdata_i = '0;

    always #5 clk = ~clk;

    l1d_lsq_arb #(.SQ_DEPTH(SQ_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ld0_req_i(ld0_req_i), .ld0_addr_i(ld0_addr_i), .ld0_gnt_o(ld0_gnt_o),
        .ld0_rvalid_o(ld0_rvalid_o), .ld0_rdata_o(ld0_rdata_o),
        .ld1_req_i(ld1_req_i), .ld1_addr_i(ld1_addr_i), .ld1_gnt_o(ld1_gnt_o),
        .ld1_rvalid_o(ld1_rvalid_o), .ld1_rdata_o(ld1_rdata_o),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_rdy_o(st_rdy_o), .st_commit_i(st_commit_i), .flush_i(flush_i),
        .sq_cnt_o(sq_cnt_o), .sq_empty_o(sq_empty_o),
        .l1d_re_o(l1d_re_o), .l1d_raddr_o(l1d_raddr_o),
        .l1d_re_i(l1d_re_i), .l1d_rdata_i(l1d_rdata_i),
        .l1d_we_o(l1d_we_o), .l1d_waddr_o(l1d_waddr_o), .l1d_wdata_o(l1d_wdata_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the store queue as an ordered list, oldest first
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          cm;
    } ent_t;

    ent_t        mq[$];
    bit          m_rr;          // 0: ld0 preferred on conflict
    bit          m_pv, m_po;    // response expected next cycle, and for which load
    logic [31:0] m_pd;
    bit          last_g0, last_g1;

    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] ram     [logic [29:0]];
    bit          ram_pend;
    logic [31:0] ram_val;

    function automatic logic [31:0] seed(input logic [29:0] w);
        return {w[13:0], 2'b01, ~w[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : seed(w);
    endfunction

    function automatic logic [31:0] rd_ram(input logic [29:0] w);
        return ram.exists(w) ? ram[w] : seed(w);
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h200 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // One clock cycle: drive inputs, check all outputs at the falling edge, advance the model.
    task automatic step(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                        input bit sr, input logic [31:0] sa, input logic [31:0] sd,
                        input bit cm, input bit fl);
        bit          eg0, eg1, hit, exp_re, exp_we, enq_ok;
        logic [31:0] ga, fd;
        ld0_req_i = r0; ld0_addr_i = a0;
        ld1_req_i = r1; ld1_addr_i = a1;
        st_req_i = sr; st_addr_i = sa; st_data_i = sd;
        st_commit_i = cm; flush_i = fl;
        @(negedge clk);

        eg0 = r0 && (!r1 || !m_rr);
        eg1 = r1 && (!r0 ||  m_rr);
        ga  = eg0 ? a0 : a1;
        hit = 1'b0;
        fd  = '0;
        foreach (mq[i]) if (mq[i].addr[31:2] == ga[31:2]) begin hit = 1'b1; fd = mq[i].data; end
        exp_re = (eg0 || eg1) && !hit;
        exp_we = (mq.size() > 0) && mq[0].cm;

        check("gnt0", ld0_gnt_o, eg0);
        check("gnt1", ld1_gnt_o, eg1);
        check("l1d_re", l1d_re_o, exp_re);
        if (exp_re) check("l1d_raddr", l1d_raddr_o, ga);
        check("l1d_we", l1d_we_o, exp_we);
        if (exp_we) begin
            check("l1d_waddr", l1d_waddr_o, mq[0].addr);
            check("l1d_wdata", l1d_wdata_o, mq[0].data);
        end
        check("rvalid0", ld0_rvalid_o, m_pv && !m_po);
        check("rvalid1", ld1_rvalid_o, m_pv &&  m_po);
        if (m_pv && !m_po) check("rdata0", ld0_rdata_o, m_pd);
        if (m_pv &&  m_po) check("rdata1", ld1_rdata_o, m_pd);
        check("sq_cnt", sq_cnt_o, mq.size());
        check("st_rdy", st_rdy_o, mq.size() < SQ_DEPTH);
        check("sq_empty", sq_empty_o, mq.size() == 0);

        // The RAM serves whatever the DUT actually drives; read sees pre-write contents.
        ram_pend = l1d_re_o;
        if (l1d_re_o) ram_val = rd_ram(l1d_raddr_o[31:2]);
        if (l1d_we_o) ram[l1d_waddr_o[31:2]] = l1d_wdata_o;

        m_pv = eg0 || eg1;
        m_po = eg1;
        m_pd = hit ? fd : rd_ref(ga[31:2]);
        if (eg0)      m_rr = 1'b1;
        else if (eg1) m_rr = 1'b0;

        enq_ok = sr && (mq.size() < SQ_DEPTH);
        if (exp_we) begin
            ref_mem[mq[0].addr[31:2]] = mq[0].data;
            void'(mq.pop_front());
        end
        if (cm) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].cm) begin mq[i].cm = 1'b1; break; end
            end
        end
        if (fl) begin
            while (mq.size() > 0 && !mq[mq.size()-1].cm) void'(mq.pop_back());
        end else if (enq_ok) begin
            mq.push_back('{sa, sd, 1'b0});
        end
        last_g0 = eg0;
        last_g1 = eg1;

        @(posedge clk);
        #1;
        l1d_re_i    = ram_pend;
        l1d_rdata_i = ram_pend ? ram_val : $urandom();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic apply_reset();
        #2;
        rst = 1'b0;
        ld0_req_i = 1'b0; ld1_req_i = 1'b0; st_req_i = 1'b0;
        st_commit_i = 1'b0; flush_i = 1'b0; l1d_re_i = 1'b0;
        #1;
        check("rst_gnt0", ld0_gnt_o, 1'b0);
        check("rst_gnt1", ld1_gnt_o, 1'b0);
        check("rst_re", l1d_re_o, 1'b0);
        check("rst_we", l1d_we_o, 1'b0);
        check("rst_rvalid", {ld0_rvalid_o, ld1_rvalid_o}, 2'b00);
        check("rst_rdata", {ld0_rdata_o, ld1_rdata_o}, 64'h0);
        check("rst_wdata", l1d_wdata_o, 32'h0);
        check("rst_cnt", sq_cnt_o, 3'd0);
        check("rst_rdy", st_rdy_o, 1'b1);
        check("rst_empty", sq_empty_o, 1'b1);
        mq.delete();
        m_rr = 1'b0; m_pv = 1'b0; ram_pend = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    bit          p0, p1;
    logic [31:0] pa0, pa1;

    initial begin
        ref_mem[30'h40] = 32'hDEADBEEF;   // byte address 0x100
        ram[30'h40]     = 32'hDEADBEEF;
        apply_reset();

        // Reset with a committed and an uncommitted store queued plus a load in flight
        step(0, 0, 0, 0, 1, 32'h300, 32'h11, 0, 0);
        step(1, 32'h100, 0, 0, 1, 32'h304, 32'h22, 1, 0);
        apply_reset();
        idle(2);

        // Plain L1D read
        step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Alternation from reset, then ld1 alone
        apply_reset();
        for (int k = 0; k < 6; k++) step(1, 32'h104, 1, 32'h108, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 32'h10C, 0, 0, 0, 0, 0);
        idle(1);

        // Forwarding, including youngest-match selection
        step(0, 0, 0, 0, 1, 32'h200, 32'h12345678, 0, 0);
        step(0, 0, 1, 32'h203, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h208, 32'h1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h208, 32'h2, 0, 0);
        step(1, 32'h20A, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Full queue, ignored fifth store, two commits drain back to back
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 32'h400 + 32'(k * 4), 32'hA0 + 32'(k), 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // One committed plus two uncommitted, then flush with a same-cycle store
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'h500, 32'hB0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h504, 32'hB1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h508, 32'hB2, 1, 0);
        step(0, 0, 0, 0, 1, 32'h50C, 32'hB3, 0, 1);
        idle(2);

        // Randomized traffic with a mid-run reset
        p0 = 0; p1 = 0; pa0 = 0; pa1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin apply_reset(); p0 = 0; p1 = 0; end
            if (!p0 && $urandom_range(0, 9) < 4) begin p0 = 1; pa0 = rand_addr(); end
            if (!p1 && $urandom_range(0, 9) < 4) begin p1 = 1; pa1 = rand_addr(); end
            step(p0, pa0, p1, pa1, $urandom_range(0, 1) == 1, rand_addr(), $urandom(),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
            if (last_g0) p0 = 0;
            if (last_g1) p1 = 0;
        end
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Memory written by the DUT must equal memory written by the model
        check("mem_words", ram.num(), ref_mem.num());
        foreach (ref_mem[w]) check("mem_data", rd_ram(w), ref_mem[w]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
